// File: rtl/adder8_seq_ctrl.sv
// Multi-byte adder sequencer: walks one shared external 8-bit adder limb by limb, chaining carry internally.
// Optional subtract mode is enabled by defining ADDER8_SEQ_SUB_EN (adds the sub input port).
module adder8_seq_ctrl #(
    parameter int NBYTES = 2,
    parameter int IDXW   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   op_a,
    input  logic [8*NBYTES-1:0]   op_b,
    input  logic                  cin,
`ifdef ADDER8_SEQ_SUB_EN
    input  logic                  sub,
`endif
    output logic [7:0]            add_A,
    output logic [7:0]            add_B,
    output logic                  add_Cin,
    input  logic [7:0]            add_Sum,
    input  logic                  add_Cout,
    output logic [8*NBYTES-1:0]   result,
    output logic                  cout,
    output logic                  zero,
    output logic                  busy,
    output logic                  done,
    output logic [IDXW-1:0]       byte_idx
);

    localparam int              W        = 8 * NBYTES;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_result;
    logic            r_carry;
    logic            r_cout;
    logic            r_zero;
    logic            r_busy;
    logic            r_done;
    logic [IDXW-1:0] r_idx;
`ifdef ADDER8_SEQ_SUB_EN
    logic            r_sub;
`endif

    logic [7:0]      w_a_byte;
    logic [7:0]      w_b_byte;
    logic [7:0]      w_b_drive;
    logic [W-1:0]    w_result_next;
    logic            w_in_add;
    logic            w_init_carry;

    // Current limb select and the result with the current limb replaced by the adder's sum.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_a_byte      = 8'h00;
        w_b_byte      = 8'h00;
        w_result_next = r_result;
        for (int i = 0; i < NBYTES; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_a_byte                = r_a[8*i +: 8];
                w_b_byte                = r_b[8*i +: 8];
                w_result_next[8*i +: 8] = add_Sum;
            end
        end
    end

`ifdef ADDER8_SEQ_SUB_EN
    assign w_b_drive    = r_sub ? ~w_b_byte : w_b_byte;
    assign w_init_carry = sub ? 1'b1 : cin;
`else
    assign w_b_drive    = w_b_byte;
    assign w_init_carry = cin;
`endif

    assign w_in_add = (r_state == S_ADD);
    assign add_A    = w_in_add ? w_a_byte  : 8'h00;
    assign add_B    = w_in_add ? w_b_drive : 8'h00;
    assign add_Cin  = w_in_add & r_carry;

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_zero   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_idx    <= '0;
`ifdef ADDER8_SEQ_SUB_EN
            r_sub    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a      <= op_a;
                        r_b      <= op_b;
                        r_carry  <= w_init_carry;
                        r_idx    <= '0;
                        r_result <= '0;
                        r_busy   <= 1'b1;
`ifdef ADDER8_SEQ_SUB_EN
                        r_sub    <= sub;
`endif
                        r_state  <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_result <= w_result_next;
                    r_carry  <= add_Cout;
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= add_Cout;
                        r_zero  <= (w_result_next == '0);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign result   = r_result;
    assign cout     = r_cout;
    assign zero     = r_zero;
    assign busy     = r_busy;
    assign done     = r_done;
    assign byte_idx = r_idx;

endmodule
